// File: rtl/store_coalesce_buffer.sv
// Write-coalescing store buffer. Committed stores are merged into line-wide entries,
// and the entries drain one masked line write at a time to the write-back data cache.
module store_coalesce_buffer #(
  parameter int unsigned ADDR_WIDTH  = 56,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned LINE_WIDTH  = 128,
  parameter int unsigned NR_ENTRIES  = 4,
  parameter int unsigned COALESCE_EN = 1,
  parameter int unsigned COALESCE_TH = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    st_valid_i,
  output logic                    st_ready_o,
  input  logic [ADDR_WIDTH-1:0]   st_addr_i,
  input  logic [DATA_WIDTH-1:0]   st_data_i,
  input  logic [DATA_WIDTH/8-1:0] st_be_i,
  output logic                    wr_valid_o,
  input  logic                    wr_ready_i,
  output logic [ADDR_WIDTH-1:0]   wr_addr_o,
  output logic [LINE_WIDTH-1:0]   wr_data_o,
  output logic [LINE_WIDTH/8-1:0] wr_be_o,
  input  logic                    flush_i,
  output logic                    empty_o,
  input  logic [ADDR_WIDTH-1:0]   ld_addr_i,
  output logic                    ld_hit_o
);

  localparam int unsigned DATA_BYTES = DATA_WIDTH / 8;
  localparam int unsigned LINE_BYTES = LINE_WIDTH / 8;
  localparam int unsigned WORDS      = LINE_WIDTH / DATA_WIDTH;
  localparam int unsigned OFF_BITS   = $clog2(LINE_BYTES);
  localparam int unsigned WORD_BITS  = $clog2(DATA_BYTES);
  localparam int unsigned TAG_W      = ADDR_WIDTH - OFF_BITS;
  localparam int unsigned WIDX_W     = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned AGE_W      = (COALESCE_TH > 0) ? $clog2(COALESCE_TH + 1) : 1;

  typedef enum logic {IDLE, DRAIN} state_t;

  // Entry state
  logic [NR_ENTRIES-1:0] valid_reg;
  logic [NR_ENTRIES-1:0] locked_reg;
  logic [TAG_W-1:0]      tag_reg  [NR_ENTRIES];
  logic [LINE_WIDTH-1:0] data_reg [NR_ENTRIES];
  logic [LINE_BYTES-1:0] be_reg   [NR_ENTRIES];
  logic [AGE_W-1:0]      age_reg  [NR_ENTRIES];

  // Drain FSM and registered write port
  state_t                state_reg;
  logic                  wr_valid_reg;
  logic [ADDR_WIDTH-1:0] wr_addr_reg;
  logic [LINE_WIDTH-1:0] wr_data_reg;
  logic [LINE_BYTES-1:0] wr_be_reg;

  logic [TAG_W-1:0]      st_tag;
  logic [TAG_W-1:0]      ld_tag;
  logic [WIDX_W-1:0]     st_widx;
  logic [LINE_BYTES-1:0] st_line_be;
  logic [LINE_WIDTH-1:0] st_bit_mask;
  logic [LINE_WIDTH-1:0] st_line_data;

  logic [NR_ENTRIES-1:0] st_match, ld_match, eligible;
  logic [NR_ENTRIES-1:0] merge_oh, alloc_oh, sel_oh;
  logic [NR_ENTRIES-1:0] do_merge, do_alloc;
  logic [LINE_WIDTH-1:0] data_next [NR_ENTRIES];
  logic [LINE_BYTES-1:0] be_next   [NR_ENTRIES];

  logic merge_hit, locked_match, free_any, st_fire, full_stall;
  logic drain_start, drain_done;
  logic [TAG_W-1:0]      sel_tag;
  logic [LINE_WIDTH-1:0] sel_data;
  logic [LINE_BYTES-1:0] sel_be;
  logic                  unused_addr_bits;

  assign st_tag = st_addr_i[ADDR_WIDTH-1:OFF_BITS];
  assign ld_tag = ld_addr_i[ADDR_WIDTH-1:OFF_BITS];
  assign unused_addr_bits = ^{st_addr_i[OFF_BITS-1:0], ld_addr_i[OFF_BITS-1:0]};

  if (WORDS > 1) begin : g_widx
    assign st_widx = st_addr_i[OFF_BITS-1:WORD_BITS];
  end else begin : g_widx_one
    assign st_widx = '0;
  end

  // Place the store word at its offset; only enabled bytes carry data.
  assign st_line_be = LINE_BYTES'(st_be_i) << (st_widx * DATA_BYTES);
  for (genvar gi = 0; gi < LINE_BYTES; gi++) begin : g_bmask
    assign st_bit_mask[gi*8 +: 8] = {8{st_line_be[gi]}};
  end
  assign st_line_data = (LINE_WIDTH'(st_data_i) << (st_widx * DATA_WIDTH)) & st_bit_mask;

  assign merge_oh     = (COALESCE_EN != 0) ? (st_match & ~locked_reg) : '0;
  assign merge_hit    = |merge_oh;
  assign locked_match = |(st_match & locked_reg);
  assign free_any     = ~&valid_reg;
  assign alloc_oh     = ~valid_reg & (valid_reg + NR_ENTRIES'(1));
  assign st_ready_o   = !rst_i && !locked_match && (merge_hit || free_any);
  assign st_fire      = st_valid_i && st_ready_o;
  assign full_stall   = (&valid_reg) && st_valid_i && !st_ready_o;

  for (genvar gi = 0; gi < NR_ENTRIES; gi++) begin : g_entry
    assign st_match[gi] = valid_reg[gi] && (tag_reg[gi] == st_tag);
    assign ld_match[gi] = valid_reg[gi] && (tag_reg[gi] == ld_tag);
    assign eligible[gi] = valid_reg[gi] && !locked_reg[gi] &&
                          ((age_reg[gi] == AGE_W'(COALESCE_TH)) || (&be_reg[gi]) ||
                           (COALESCE_EN == 0) || flush_i || full_stall);
    assign do_merge[gi] = st_fire && merge_oh[gi];
    assign do_alloc[gi] = st_fire && !merge_hit && alloc_oh[gi];
    assign data_next[gi] = do_merge[gi] ? ((data_reg[gi] & ~st_bit_mask) | st_line_data) :
                           do_alloc[gi] ? st_line_data : data_reg[gi];
    assign be_next[gi]   = do_merge[gi] ? (be_reg[gi] | st_line_be) :
                           do_alloc[gi] ? st_line_be : be_reg[gi];
  end

  assign sel_oh      = eligible & (~eligible + NR_ENTRIES'(1));
  assign drain_start = (state_reg == IDLE) && (|eligible);
  assign drain_done  = (state_reg == DRAIN) && wr_ready_i;

  // A store merging in the same cycle the entry gets locked is captured too,
  // so the output registers take the post-merge contents.
  always_comb begin
    sel_tag  = '0;
    sel_data = '0;
    sel_be   = '0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      if (sel_oh[i]) begin
        sel_tag  = sel_tag | tag_reg[i];
        sel_data = sel_data | data_next[i];
        sel_be   = sel_be | be_next[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_reg  <= '0;
      locked_reg <= '0;
      for (int i = 0; i < NR_ENTRIES; i++) begin
        tag_reg[i]  <= '0;
        data_reg[i] <= '0;
        be_reg[i]   <= '0;
        age_reg[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        data_reg[i] <= data_next[i];
        be_reg[i]   <= be_next[i];
        if (do_alloc[i]) begin
          valid_reg[i] <= 1'b1;
          tag_reg[i]   <= st_tag;
        end else if (drain_done && locked_reg[i]) begin
          valid_reg[i]  <= 1'b0;
          locked_reg[i] <= 1'b0;
        end
        if (drain_start && sel_oh[i]) locked_reg[i] <= 1'b1;
        if (do_merge[i] || do_alloc[i]) begin
          age_reg[i] <= '0;
        end else if (valid_reg[i] && !locked_reg[i] && (age_reg[i] != AGE_W'(COALESCE_TH))) begin
          age_reg[i] <= age_reg[i] + AGE_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      wr_valid_reg <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
      wr_be_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (drain_start) begin
            state_reg    <= DRAIN;
            wr_valid_reg <= 1'b1;
            wr_addr_reg  <= {sel_tag, {OFF_BITS{1'b0}}};
            wr_data_reg  <= sel_data;
            wr_be_reg    <= sel_be;
          end
        end
        DRAIN: begin
          if (wr_ready_i) begin
            state_reg    <= IDLE;
            wr_valid_reg <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign wr_valid_o = wr_valid_reg && !rst_i;
  assign wr_addr_o  = rst_i ? '0 : wr_addr_reg;
  assign wr_data_o  = rst_i ? '0 : wr_data_reg;
  assign wr_be_o    = rst_i ? '0 : wr_be_reg;
  assign empty_o    = rst_i || (!(|valid_reg) && (state_reg == IDLE));
  assign ld_hit_o   = |ld_match;

endmodule

// File: tb/tb_store_coalesce_buffer.sv
// Directed and randomized checks of store_coalesce_buffer at thresholds 0, 3 and 15,
// with a per-line pending-bytes model for the randomized phase.
module tb_store_coalesce_buffer;

  localparam int NI = 3;

  logic         clk;
  logic         rst;
  logic         st_valid [NI];
  logic         st_ready [NI];
  logic [55:0]  st_addr  [NI];
  logic [63:0]  st_data  [NI];
  logic [7:0]   st_be    [NI];
  logic         wr_valid [NI];
  logic         wr_ready [NI];
  logic [55:0]  wr_addr  [NI];
  logic [127:0] wr_data  [NI];
  logic [15:0]  wr_be    [NI];
  logic         flush    [NI];
  logic         empty    [NI];
  logic [55:0]  ld_addr  [NI];
  logic         ld_hit   [NI];

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int unsigned TH = (gi == 0) ? 0 : (gi == 1) ? 3 : 15;
    store_coalesce_buffer #(.COALESCE_TH(TH)) u_dut (
      .clk_i(clk), .rst_i(rst),
      .st_valid_i(st_valid[gi]), .st_ready_o(st_ready[gi]),
      .st_addr_i(st_addr[gi]), .st_data_i(st_data[gi]), .st_be_i(st_be[gi]),
      .wr_valid_o(wr_valid[gi]), .wr_ready_i(wr_ready[gi]),
      .wr_addr_o(wr_addr[gi]), .wr_data_o(wr_data[gi]), .wr_be_o(wr_be[gi]),
      .flush_i(flush[gi]), .empty_o(empty[gi]),
      .ld_addr_i(ld_addr[gi]), .ld_hit_o(ld_hit[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference model: bytes accepted for each line and not yet written out.
  logic [15:0]  pend_be   [logic [55:0]];
  logic [127:0] pend_data [logic [55:0]];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] bmask(input logic [15:0] be);
    logic [127:0] m = '0;
    for (int b = 0; b < 16; b++) if (be[b]) m[b*8 +: 8] = 8'hFF;
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int k, input logic [55:0] a, input logic [63:0] d, input logic [7:0] be);
    st_valid[k] = 1'b1;
    st_addr[k]  = a;
    st_data[k]  = d;
    st_be[k]    = be;
    #1;
  endtask

  task automatic wait_wr(input int k, input int max_cyc, output int n);
    n = 0;
    while (wr_valid[k] !== 1'b1 && n < max_cyc) begin
      tick();
      n++;
    end
  endtask

  task automatic drain_all(input int k, output int writes);
    writes = 0;
    wr_ready[k] = 1'b1;
    for (int c = 0; c < 100 && empty[k] !== 1'b1; c++) begin
      if (wr_valid[k] === 1'b1) writes++;
      tick();
    end
    wr_ready[k] = 1'b0;
    #1;
  endtask

  task automatic observe_write();
    logic [55:0] la;
    if (wr_valid[1] === 1'b1 && wr_ready[1] === 1'b1) begin
      la = wr_addr[1];
      check("rnd write line pending", pend_be.exists(la), 1'b1);
      if (pend_be.exists(la)) begin
        check("rnd wr_be", wr_be[1], pend_be[la]);
        check("rnd wr_data", wr_data[1] & bmask(pend_be[la]), pend_data[la]);
        pend_be.delete(la);
        pend_data.delete(la);
      end
    end
  endtask

  task automatic model_store();
    logic [55:0] la;
    int w;
    if (st_valid[1] === 1'b1 && st_ready[1] === 1'b1) begin
      la = st_addr[1] & ~56'hF;
      w  = int'(st_addr[1][3]);
      if (!pend_be.exists(la)) begin
        pend_be[la]   = '0;
        pend_data[la] = '0;
      end
      for (int b = 0; b < 8; b++) begin
        if (st_be[1][b]) begin
          pend_be[la][w*8 + b] = 1'b1;
          pend_data[la][(w*8 + b)*8 +: 8] = st_data[1][b*8 +: 8];
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d1, d2;
    int n;
    logic [55:0] q[$];

    rst = 1'b1;
    for (int k = 0; k < NI; k++) begin
      st_valid[k] = 1'b0; st_addr[k] = '0; st_data[k] = '0; st_be[k] = '0;
      wr_ready[k] = 1'b0; flush[k] = 1'b0; ld_addr[k] = '0;
    end
    tick();
    tick();
    for (int k = 0; k < NI; k++) begin
      check($sformatf("reset st_ready %0d", k), st_ready[k], 1'b0);
      check($sformatf("reset wr_valid %0d", k), wr_valid[k], 1'b0);
      check($sformatf("reset empty %0d", k), empty[k], 1'b1);
      check($sformatf("reset wr_addr %0d", k), wr_addr[k], 56'h0);
    end
    rst = 1'b0;
    tick();

    // Merge of two halves in consecutive cycles, threshold 0
    put(0, 56'h1000, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F);
    check("merge ready a", st_ready[0], 1'b1);
    tick();
    put(0, 56'h1008, 64'hBBBB_BBBB_BBBB_BBBB, 8'hF0);
    check("merge ready b", st_ready[0], 1'b1);
    check("merge no write yet", wr_valid[0], 1'b0);
    tick();
    st_valid[0] = 1'b0;
    #1;
    check("merge wr_valid", wr_valid[0], 1'b1);
    check("merge wr_addr", wr_addr[0], 56'h1000);
    check("merge wr_be", wr_be[0], 16'hF00F);
    check("merge wr_data", wr_data[0] & bmask(16'hF00F), 128'hBBBBBBBB_00000000_00000000_AAAAAAAA);
    wr_ready[0] = 1'b1;
    tick();
    wr_ready[0] = 1'b0;
    #1;
    check("merge single write", wr_valid[0], 1'b0);
    check("merge empty", empty[0], 1'b1);

    // Threshold 3: accepted in cycle 10 -> write in 15; merge in 12 -> 17
    d1 = {$urandom, $urandom};
    put(1, 56'h2000, d1, 8'h0F);
    check("th3 ready", st_ready[1], 1'b1);
    tick();
    st_valid[1] = 1'b0;
    #1;
    wait_wr(1, 30, n);
    check("th3 latency", n, 4);
    wr_ready[1] = 1'b1;
    tick();
    wr_ready[1] = 1'b0;
    #1;
    d1 = {$urandom, $urandom};
    d2 = {$urandom, $urandom};
    put(1, 56'h2000, d1, 8'h0F);
    tick();
    st_valid[1] = 1'b0;
    #1;
    tick();
    put(1, 56'h2008, d2, 8'h0F);
    check("th3 merge ready", st_ready[1], 1'b1);
    tick();
    st_valid[1] = 1'b0;
    #1;
    wait_wr(1, 30, n);
    check("th3 delayed latency", n, 4);
    check("th3 wr_addr", wr_addr[1], 56'h2000);
    check("th3 wr_be", wr_be[1], 16'h0F0F);
    check("th3 wr_data", wr_data[1] & bmask(16'h0F0F), {32'h0, d2[31:0], 32'h0, d1[31:0]});
    wr_ready[1] = 1'b1;
    tick();
    wr_ready[1] = 1'b0;
    #1;

    // Full line drains without waiting for threshold 15
    d1 = {$urandom, $urandom};
    d2 = {$urandom, $urandom};
    put(2, 56'h3000, d1, 8'hFF);
    tick();
    put(2, 56'h3008, d2, 8'hFF);
    check("full line ready", st_ready[2], 1'b1);
    tick();
    st_valid[2] = 1'b0;
    #1;
    wait_wr(2, 30, n);
    check("full line latency", n, 1);
    check("full line wr_be", wr_be[2], 16'hFFFF);
    check("full line wr_data", wr_data[2], {d2, d1});
    wr_ready[2] = 1'b1;
    tick();
    wr_ready[2] = 1'b0;
    #1;

    // Full buffer: fifth store stalls while entry 0 is held
    for (int i = 0; i < 4; i++) begin
      put(0, 56'h4000 + 56'(i * 16), {$urandom, $urandom}, 8'h01);
      check($sformatf("full buf ready %0d", i), st_ready[0], 1'b1);
      tick();
    end
    put(0, 56'h4040, {$urandom, $urandom}, 8'h01);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("full buf stall %0d", i), st_ready[0], 1'b0);
      check($sformatf("full buf wr_valid %0d", i), wr_valid[0], 1'b1);
      check($sformatf("full buf wr_addr %0d", i), wr_addr[0], 56'h4000);
      check($sformatf("full buf wr_be %0d", i), wr_be[0], 16'h0001);
      if (i < 5) tick();
    end
    wr_ready[0] = 1'b1;
    #1;
    check("full buf stall in handshake cycle", st_ready[0], 1'b0);
    tick();
    wr_ready[0] = 1'b0;
    #1;
    check("full buf ready after handshake", st_ready[0], 1'b1);
    tick();
    st_valid[0] = 1'b0;
    #1;
    drain_all(0, n);
    check("full buf remaining writes", n, 4);
    check("full buf empty", empty[0], 1'b1);

    // Store to the line under drain stalls; load probe hits it throughout
    ld_addr[0] = 56'h5008;
    d2 = {$urandom, $urandom};
    put(0, 56'h5000, {$urandom, $urandom}, 8'h01);
    check("lock ld_hit before alloc", ld_hit[0], 1'b0);
    tick();
    st_valid[0] = 1'b0;
    #1;
    check("lock ld_hit valid", ld_hit[0], 1'b1);
    tick();
    put(0, 56'h5008, d2, 8'h02);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("lock stall %0d", i), st_ready[0], 1'b0);
      check($sformatf("lock ld_hit %0d", i), ld_hit[0], 1'b1);
      check($sformatf("lock wr_valid %0d", i), wr_valid[0], 1'b1);
      tick();
    end
    wr_ready[0] = 1'b1;
    #1;
    check("lock stall at handshake", st_ready[0], 1'b0);
    check("lock not merged", wr_be[0], 16'h0001);
    tick();
    wr_ready[0] = 1'b0;
    #1;
    check("lock ready after handshake", st_ready[0], 1'b1);
    check("lock ld_hit cleared", ld_hit[0], 1'b0);
    tick();
    st_valid[0] = 1'b0;
    #1;
    check("lock ld_hit new entry", ld_hit[0], 1'b1);
    wait_wr(0, 10, n);
    check("lock new write latency", n, 1);
    check("lock new wr_addr", wr_addr[0], 56'h5000);
    check("lock new wr_be", wr_be[0], 16'h0200);
    check("lock new wr_data", wr_data[0] & bmask(16'h0200), 128'(d2[15:8]) << 72);
    wr_ready[0] = 1'b1;
    tick();
    wr_ready[0] = 1'b0;
    #1;
    check("lock empty", empty[0], 1'b1);

    // Flush drains three aging entries in index order
    wr_ready[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      put(2, 56'h6000 + 56'(i * 16), {$urandom, $urandom}, 8'h01);
      tick();
    end
    st_valid[2] = 1'b0;
    #1;
    check("flush no early drain", wr_valid[2], 1'b0);
    check("flush not empty", empty[2], 1'b0);
    flush[2] = 1'b1;
    for (int c = 0; c < 60 && empty[2] !== 1'b1; c++) begin
      if (wr_valid[2] === 1'b1) q.push_back(wr_addr[2]);
      tick();
    end
    flush[2] = 1'b0;
    wr_ready[2] = 1'b0;
    #1;
    check("flush write count", q.size(), 3);
    for (int i = 0; i < q.size(); i++)
      check($sformatf("flush order %0d", i), q[i], 56'h6000 + 56'(i * 16));
    check("flush empty", empty[2], 1'b1);

    // Reset while a write is held
    flush[2] = 1'b1;
    put(2, 56'h7000, {$urandom, $urandom}, 8'h01);
    tick();
    st_valid[2] = 1'b0;
    #1;
    wait_wr(2, 10, n);
    check("rst drain started", wr_valid[2], 1'b1);
    rst = 1'b1;
    flush[2] = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check("rst wr_valid", wr_valid[2], 1'b0);
    check("rst empty", empty[2], 1'b1);

    // Randomized traffic against the pending-bytes model, threshold 3
    for (int c = 0; c < 400; c++) begin
      st_valid[1] = ($urandom_range(0, 9) < 7);
      st_addr[1]  = 56'h8000 + 56'($urandom_range(0, 5)) * 56'd16 + 56'($urandom_range(0, 1)) * 56'd8;
      st_data[1]  = {$urandom, $urandom};
      st_be[1]    = 8'($urandom_range(1, 255));
      wr_ready[1] = ($urandom_range(0, 9) < 6);
      ld_addr[1]  = 56'h8000 + 56'($urandom_range(0, 6)) * 56'd16 + 56'($urandom_range(0, 15));
      #1;
      check("rnd ld_hit", ld_hit[1], pend_be.exists(ld_addr[1] & ~56'hF));
      observe_write();
      model_store();
      tick();
    end
    st_valid[1] = 1'b0;
    wr_ready[1] = 1'b1;
    flush[1] = 1'b1;
    #1;
    for (int c = 0; c < 200 && empty[1] !== 1'b1; c++) begin
      observe_write();
      tick();
    end
    flush[1] = 1'b0;
    wr_ready[1] = 1'b0;
    #1;
    check("rnd all lines written", pend_be.num(), 0);
    check("rnd empty", empty[1], 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
